// File: rtl/ahb_master_arbiter.sv
// Two-requester round-robin arbiter driving one AHB-Lite master port (SINGLE / INCR4, word size).
// Latency: gnt and NONSEQ appear one cycle after the grant decision; rdata and done are combinational on the completing cycle.
// Backpressure: hreadyout=0 holds the pending address phase and data phase; requests wait until the bus returns to IDLE.
module ahb_master_arbiter (
    input  logic        hclk,
    input  logic        hrst,
    input  logic [1:0]  req_valid,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_write,
    input  logic [1:0]  req_incr4,
    input  logic [63:0] req_wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  wdata_take,
    output logic [1:0]  rdata_valid,
    output logic [31:0] rdata,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hreadyout,
    input  logic [1:0]  hresp
);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, ERR2 = 2'd3} state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        rr_last, rr_last_nxt;
    logic        dp_vld, dp_vld_nxt;
    logic        dp_write, dp_write_nxt;
    logic [1:0]  beats, beats_nxt;
    logic [1:0]  gnt_nxt, htrans_nxt, owner_oh;
    logic [31:0] haddr_nxt, hwdata_nxt, sel_addr, cur_wdata;
    logic        hwrite_nxt;
    logic [2:0]  hburst_nxt;
    logic        win, dp_ok, err_first;

    assign hsize     = 3'b010;
    assign owner_oh  = owner ? 2'b10 : 2'b01;
    // On a tie the requester that did not win last time gets the bus.
    assign win       = (&req_valid) ? ~rr_last : req_valid[1];
    assign sel_addr  = win ? req_addr[63:32] : req_addr[31:0];
    assign cur_wdata = owner ? req_wdata[63:32] : req_wdata[31:0];
    assign dp_ok     = dp_vld & hreadyout & (hresp == 2'b00);
    assign err_first = dp_vld & ~hreadyout & (hresp == 2'b01);

    always_ff @(posedge hclk or negedge hrst) begin
        if (!hrst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr_last  <= 1'b1;
            dp_vld   <= 1'b0;
            dp_write <= 1'b0;
            beats    <= 2'd0;
            gnt      <= 2'b00;
            haddr    <= 32'h0;
            htrans   <= HT_IDLE;
            hwrite   <= 1'b0;
            hburst   <= 3'b000;
            hwdata   <= 32'h0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_last  <= rr_last_nxt;
            dp_vld   <= dp_vld_nxt;
            dp_write <= dp_write_nxt;
            beats    <= beats_nxt;
            gnt      <= gnt_nxt;
            haddr    <= haddr_nxt;
            htrans   <= htrans_nxt;
            hwrite   <= hwrite_nxt;
            hburst   <= hburst_nxt;
            hwdata   <= hwdata_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_last_nxt  = rr_last;
        dp_vld_nxt   = dp_vld;
        dp_write_nxt = dp_write;
        beats_nxt    = beats;
        gnt_nxt      = gnt;
        haddr_nxt    = haddr;
        htrans_nxt   = htrans;
        hwrite_nxt   = hwrite;
        hburst_nxt   = hburst;
        hwdata_nxt   = hwdata;
        wdata_take   = 2'b00;
        rdata_valid  = 2'b00;
        rdata        = 32'h0;
        done         = 2'b00;
        err          = 2'b00;

        // Read data is passed straight through on the completing cycle.
        if ((state == ADDR || state == DATA) && dp_ok && !dp_write) begin
            rdata_valid = owner_oh;
            rdata       = hrdata;
        end

        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nxt   = ADDR;
                    owner_nxt   = win;
                    rr_last_nxt = win;
                    gnt_nxt     = win ? 2'b10 : 2'b01;
                    haddr_nxt   = sel_addr & ~32'h3;
                    htrans_nxt  = HT_NONSEQ;
                    hwrite_nxt  = req_write[win];
                    hburst_nxt  = req_incr4[win] ? 3'b011 : 3'b000;
                    beats_nxt   = req_incr4[win] ? 2'd3 : 2'd0;
                end
            end
            ADDR: begin
                if (err_first) begin
                    htrans_nxt = HT_IDLE;
                    state_nxt  = ERR2;
                end else if (hreadyout) begin
                    dp_vld_nxt   = 1'b1;
                    dp_write_nxt = hwrite;
                    hwdata_nxt   = hwrite ? cur_wdata : 32'h0;
                    wdata_take   = hwrite ? owner_oh : 2'b00;
                    if (beats != 2'd0) begin
                        haddr_nxt  = haddr + 32'd4;
                        htrans_nxt = HT_SEQ;
                        beats_nxt  = beats - 2'd1;
                    end else begin
                        htrans_nxt = HT_IDLE;
                        state_nxt  = DATA;
                    end
                end
            end
            DATA: begin
                if (err_first) begin
                    state_nxt = ERR2;
                end else if (hreadyout) begin
                    done       = owner_oh;
                    err        = (hresp != 2'b00) ? owner_oh : 2'b00;
                    gnt_nxt    = 2'b00;
                    dp_vld_nxt = 1'b0;
                    hwdata_nxt = 32'h0;
                    state_nxt  = IDLE;
                end
            end
            ERR2: begin
                if (hreadyout) begin
                    done       = owner_oh;
                    err        = owner_oh;
                    gnt_nxt    = 2'b00;
                    dp_vld_nxt = 1'b0;
                    hwdata_nxt = 32'h0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: requester and AHB slave models feed a tagged event scoreboard.
module tb_ahb_master_arbiter;

    logic        hclk, hrst;
    logic [1:0]  req_valid, req_write, req_incr4;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  gnt, wdata_take, rdata_valid, done, err;
    logic [31:0] rdata, haddr, hwdata, hrdata;
    logic [1:0]  htrans, hresp;
    logic        hwrite, hreadyout;
    logic [2:0]  hsize, hburst;

    ahb_master_arbiter dut (
        .hclk(hclk), .hrst(hrst), .req_valid(req_valid), .req_addr(req_addr),
        .req_write(req_write), .req_incr4(req_incr4), .req_wdata(req_wdata),
        .gnt(gnt), .wdata_take(wdata_take), .rdata_valid(rdata_valid), .rdata(rdata),
        .done(done), .err(err), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata),
        .hreadyout(hreadyout), .hresp(hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;
    int viol = 0;
    int take_cnt = 0;

    logic [63:0] exp_q[$];
    logic [63:0] obs_q[$];

    logic [31:0] wbase [2];
    int          wbeat [2];
    logic [1:0]  drop_req;

    // slave model state and wait/error plan
    logic        sl_pend, sl_wr, sl_err, sl_estage;
    logic [31:0] sl_addr;
    int          sl_beat, sl_wait;
    int          wait_beat, wait_n, err_beat;

    logic [1:0]  s_gnt, s_htrans;
    logic [31:0] s_haddr;
    logic [1:0]  p_htrans, p_resp, p_gnt;
    logic [31:0] p_haddr;
    logic        p_hwrite, p_ready, p_err1;
    logic [2:0]  p_hburst;

    function automatic logic [31:0] rdv(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic issue(input int i, input logic [31:0] addr, input logic wr, input logic incr4,
                         input int n_acc, input int n_ok, input logic errd, input logic [31:0] wb);
        logic [31:0] a0;
        logic [1:0]  g;
        g = 2'b01 << i;
        a0 = {addr[31:2], 2'b00};
        req_addr[32*i +: 32]  = addr;
        req_wdata[32*i +: 32] = wb;
        req_write[i] = wr;
        req_incr4[i] = incr4;
        wbase[i] = wb;
        wbeat[i] = 0;
        req_valid[i] = 1'b1;
        for (int k = 0; k < n_acc; k++)
            exp_q.push_back({4'h1, 20'h0, g, (incr4 ? 3'b011 : 3'b000), wr,
                             (k == 0 ? 2'b10 : 2'b11), a0 + 32'(4 * k)});
        for (int k = 0; k < n_ok; k++)
            exp_q.push_back({4'h2, 25'h0, g, wr,
                             (wr ? wb + 32'(k) * 32'h01010101 : rdv(a0 + 32'(4 * k)))});
        exp_q.push_back({4'h3, 56'h0, g, (errd ? g : 2'b00)});
    endtask

    // One bus cycle: drive slave response, sample mid-cycle, record events, advance models.
    task automatic tick();
        logic [1:0] take, dn;
        if (!sl_pend || sl_wait > 0) begin
            hreadyout = !sl_pend; hresp = 2'b00; hrdata = 32'hDEADBEEF;
        end else if (sl_err) begin
            hreadyout = sl_estage; hresp = 2'b01; hrdata = 32'hDEADBEEF;
        end else begin
            hreadyout = 1'b1; hresp = 2'b00; hrdata = rdv(sl_addr);
        end
        #4;
        s_gnt = gnt; s_htrans = htrans; s_haddr = haddr;
        if (hrst) begin
            if ($countones(gnt) > 1 || $countones(wdata_take) > 1 || $countones(rdata_valid) > 1 ||
                $countones(done) > 1 || $countones(err) > 1 || hsize != 3'b010) viol++;
            if (p_htrans[1] && !p_ready && p_resp == 2'b00 &&
                {htrans, haddr, hwrite, hburst} != {p_htrans, p_haddr, p_hwrite, p_hburst}) viol++;
            if (p_err1 && htrans != 2'b00) viol++;
            if (p_gnt != 2'b00 && gnt != 2'b00 && p_gnt != gnt) viol++;
            if (wdata_take != ((htrans[1] && hreadyout && hwrite) ? gnt : 2'b00)) viol++;
            if (rdata_valid != 2'b00 && !(sl_pend && !sl_wr && hreadyout && hresp == 2'b00)) viol++;
            if (sl_pend && !sl_wr && hwdata != 32'h0) viol++;
            if (done == 2'b00 && err != 2'b00) viol++;
            if (htrans[1] && hreadyout)
                obs_q.push_back({4'h1, 20'h0, gnt, hburst, hwrite, htrans, haddr});
            if (sl_pend && hreadyout && hresp == 2'b00)
                obs_q.push_back(sl_wr ? {4'h2, 25'h0, gnt, 1'b1, hwdata}
                                      : {4'h2, 25'h0, rdata_valid, 1'b0, rdata});
            if (done != 2'b00) obs_q.push_back({4'h3, 56'h0, done, err});
            take_cnt += $countones(wdata_take);
        end
        take = wdata_take; dn = done;
        p_htrans = htrans; p_haddr = haddr; p_hwrite = hwrite; p_hburst = hburst;
        p_ready = hreadyout; p_resp = hresp; p_gnt = gnt;
        p_err1 = sl_pend && !hreadyout && hresp == 2'b01;
        if (!hrst) begin
            sl_pend = 1'b0;
        end else begin
            if (sl_pend) begin
                if (hreadyout) sl_pend = 1'b0;
                else if (sl_wait > 0) sl_wait--;
                else if (sl_err) sl_estage = 1'b1;
            end
            if (htrans[1] && hreadyout) begin
                sl_pend = 1'b1; sl_addr = haddr; sl_wr = hwrite;
                sl_beat = (htrans == 2'b10) ? 1 : sl_beat + 1;
                sl_wait = (sl_beat == wait_beat) ? wait_n : 0;
                sl_err = (sl_beat == err_beat);
                sl_estage = 1'b0;
            end
        end
        @(posedge hclk);
        #1;
        req_valid = req_valid & ~dn & ~(drop_req & s_gnt);
        for (int i = 0; i < 2; i++)
            if (take[i]) begin
                wbeat[i]++;
                req_wdata[32*i +: 32] = wbase[i] + 32'(wbeat[i]) * 32'h01010101;
            end
    endtask

    task automatic run_idle(input int budget, output bit to);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(req_valid == 2'b00 && s_gnt == 2'b00) && n < budget);
        to = !(req_valid == 2'b00 && s_gnt == 2'b00);
    endtask

    task automatic test_reset();
        checks++;
        if ({gnt, wdata_take, rdata_valid, done, err, htrans, hwrite, hburst} !== 17'h0 ||
            haddr !== 32'h0 || hwdata !== 32'h0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b htrans=%b haddr=%h hwdata=%h rdata=%h want all zero",
                     gnt, htrans, haddr, hwdata, rdata);
        end
        checks++;
        if (hsize !== 3'b010) begin
            errors++; $display("FAIL reset_hsize: got %b want 010", hsize);
        end
        hrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (s_gnt !== 2'b00 || s_htrans !== 2'b00) begin
                errors++; $display("FAIL idle_no_req: got gnt=%b htrans=%b want 00/00", s_gnt, s_htrans);
            end
        end
    endtask

    task automatic test_single_write();
        bit to;
        logic [63:0] e, o;
        bit found;
        take_cnt = 0; viol = 0;
        issue(0, 32'h100, 1'b1, 1'b0, 1, 1, 1'b0, 32'hA5A5A5A5);
        tick();
        checks++;
        if (s_gnt !== 2'b00 || s_htrans !== 2'b00) begin
            errors++; $display("FAIL sw_decide_cycle: got gnt=%b htrans=%b want 00/00", s_gnt, s_htrans);
        end
        tick();
        checks++;
        if ({s_gnt, s_htrans, s_haddr} !== {2'b01, 2'b10, 32'h100}) begin
            errors++; $display("FAIL sw_nonseq: got gnt=%b htrans=%b haddr=%h want 01/10/00000100",
                               s_gnt, s_htrans, s_haddr);
        end
        run_idle(100, to);
        checks++;
        if (to) begin errors++; $display("FAIL sw_timeout: got busy want idle"); end
        checks++;
        if (take_cnt != 1) begin errors++; $display("FAIL sw_takes: got %0d want 1", take_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); found = 0; o = 64'h0;
            for (int j = 0; j < obs_q.size(); j++)
                if (obs_q[j][63:60] == e[63:60]) begin o = obs_q[j]; obs_q.delete(j); found = 1; break; end
            checks++;
            if (!found || o !== e) begin errors++; $display("FAIL sw_event: got %h want %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL sw_extra: got %0d events want 0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL sw_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_incr4_read_wait();
        bit to;
        logic [63:0] e, o;
        bit found;
        take_cnt = 0; viol = 0; wait_beat = 2; wait_n = 2;
        issue(1, 32'h200, 1'b0, 1'b1, 4, 4, 1'b0, 32'h0);
        run_idle(100, to);
        wait_beat = 0;
        checks++;
        if (to) begin errors++; $display("FAIL rd_timeout: got busy want idle"); end
        checks++;
        if (take_cnt != 0) begin errors++; $display("FAIL rd_takes: got %0d want 0", take_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); found = 0; o = 64'h0;
            for (int j = 0; j < obs_q.size(); j++)
                if (obs_q[j][63:60] == e[63:60]) begin o = obs_q[j]; obs_q.delete(j); found = 1; break; end
            checks++;
            if (!found || o !== e) begin errors++; $display("FAIL rd_event: got %h want %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL rd_extra: got %0d events want 0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL rd_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_round_robin();
        bit to;
        logic [63:0] e, o;
        bit found;
        viol = 0;
        issue(0, 32'h300, 1'b1, 1'b0, 1, 1, 1'b0, 32'h11112222);
        issue(1, 32'h400, 1'b0, 1'b0, 1, 1, 1'b0, 32'h0);
        tick(); tick();
        checks++;
        if (s_gnt !== 2'b01) begin errors++; $display("FAIL rr_tie1: got gnt=%b want 01", s_gnt); end
        run_idle(100, to);
        checks++;
        if (to) begin errors++; $display("FAIL rr_timeout1: got busy want idle"); end
        issue(0, 32'h310, 1'b0, 1'b0, 1, 1, 1'b0, 32'h0);
        issue(1, 32'h410, 1'b1, 1'b0, 1, 1, 1'b0, 32'h33334444);
        tick(); tick();
        checks++;
        if (s_gnt !== 2'b01) begin errors++; $display("FAIL rr_tie2: got gnt=%b want 01", s_gnt); end
        run_idle(100, to);
        checks++;
        if (to) begin errors++; $display("FAIL rr_timeout2: got busy want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); found = 0; o = 64'h0;
            for (int j = 0; j < obs_q.size(); j++)
                if (obs_q[j][63:60] == e[63:60]) begin o = obs_q[j]; obs_q.delete(j); found = 1; break; end
            checks++;
            if (!found || o !== e) begin errors++; $display("FAIL rr_event: got %h want %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL rr_extra: got %0d events want 0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL rr_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [63:0] e, o;
        bit found;
        viol = 0;
        issue(0, 32'hFFFF_FFFA, 1'b1, 1'b1, 4, 4, 1'b0, 32'h01020304);
        tick(); tick();
        issue(1, 32'h1000, 1'b0, 1'b1, 4, 4, 1'b0, 32'h0);
        drop_req = 2'b10;
        run_idle(200, to);
        drop_req = 2'b00;
        checks++;
        if (to) begin errors++; $display("FAIL b2b_timeout: got busy want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); found = 0; o = 64'h0;
            for (int j = 0; j < obs_q.size(); j++)
                if (obs_q[j][63:60] == e[63:60]) begin o = obs_q[j]; obs_q.delete(j); found = 1; break; end
            checks++;
            if (!found || o !== e) begin errors++; $display("FAIL b2b_event: got %h want %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL b2b_extra: got %0d events want 0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL b2b_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_error();
        bit to;
        logic [63:0] e, o;
        bit found;
        take_cnt = 0; viol = 0; err_beat = 2;
        issue(0, 32'h500, 1'b1, 1'b1, 2, 1, 1'b1, 32'hCAFE0000);
        run_idle(100, to);
        err_beat = 0;
        checks++;
        if (to) begin errors++; $display("FAIL err_timeout: got busy want idle"); end
        checks++;
        if (take_cnt != 2) begin errors++; $display("FAIL err_takes: got %0d want 2", take_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); found = 0; o = 64'h0;
            for (int j = 0; j < obs_q.size(); j++)
                if (obs_q[j][63:60] == e[63:60]) begin o = obs_q[j]; obs_q.delete(j); found = 1; break; end
            checks++;
            if (!found || o !== e) begin errors++; $display("FAIL err_event: got %h want %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL err_extra: got %0d events want 0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL err_protocol: got %0d violations want 0", viol); end
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [63:0] e, o;
        bit found;
        viol = 0; wait_beat = 2; wait_n = 3;
        issue(0, 32'h600, 1'b0, 1'b1, 4, 4, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) tick();
        #2;
        hrst = 1'b0;
        #1;
        checks++;
        if ({gnt, wdata_take, rdata_valid, done, err, htrans, hwrite, hburst} !== 17'h0 ||
            haddr !== 32'h0 || hwdata !== 32'h0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got gnt=%b htrans=%b haddr=%h hwdata=%h want all zero",
                     gnt, htrans, haddr, hwdata);
        end
        req_valid = 2'b00; wait_beat = 0;
        exp_q.delete(); obs_q.delete();
        tick(); tick();
        hrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (s_gnt !== 2'b00 || s_htrans !== 2'b00) begin
                errors++; $display("FAIL rst_mid_idle: got gnt=%b htrans=%b want 00/00", s_gnt, s_htrans);
            end
        end
        issue(0, 32'h700, 1'b0, 1'b0, 1, 1, 1'b0, 32'h0);
        issue(1, 32'h704, 1'b1, 1'b0, 1, 1, 1'b0, 32'h77777777);
        tick(); tick();
        checks++;
        if (s_gnt !== 2'b01) begin errors++; $display("FAIL rst_mid_priority: got gnt=%b want 01", s_gnt); end
        run_idle(100, to);
        checks++;
        if (to) begin errors++; $display("FAIL rst_mid_timeout: got busy want idle"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); found = 0; o = 64'h0;
            for (int j = 0; j < obs_q.size(); j++)
                if (obs_q[j][63:60] == e[63:60]) begin o = obs_q[j]; obs_q.delete(j); found = 1; break; end
            checks++;
            if (!found || o !== e) begin errors++; $display("FAIL rst_mid_event: got %h want %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL rst_mid_extra: got %0d events want 0", obs_q.size()); obs_q.delete();
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL rst_mid_protocol: got %0d violations want 0", viol); end
    endtask

    initial begin
        hrst = 1'b0;
        req_valid = 2'b00; req_write = 2'b00; req_incr4 = 2'b00;
        req_addr = 64'h0; req_wdata = 64'h0;
        hrdata = 32'h0; hreadyout = 1'b1; hresp = 2'b00;
        drop_req = 2'b00;
        sl_pend = 1'b0; sl_wr = 1'b0; sl_err = 1'b0; sl_estage = 1'b0; sl_addr = 32'h0;
        sl_beat = 0; sl_wait = 0; wait_beat = 0; wait_n = 0; err_beat = 0;
        p_htrans = 2'b00; p_resp = 2'b00; p_gnt = 2'b00; p_haddr = 32'h0;
        p_hwrite = 1'b0; p_ready = 1'b1; p_err1 = 1'b0; p_hburst = 3'b000;
        s_gnt = 2'b00; s_htrans = 2'b00; s_haddr = 32'h0;
        wbase[0] = 32'h0; wbase[1] = 32'h0; wbeat[0] = 0; wbeat[1] = 0;
        repeat (2) @(posedge hclk);
        #1;
        test_reset();
        test_single_write();
        test_incr4_read_wait();
        test_round_robin();
        test_back_to_back();
        test_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 SHALL have port hclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port hrst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port req_valid, input, 2 bits: bit i is a transfer request from requester i, held high until done[i].
REQ-004 SHALL have port req_addr, input, 64 bits: requester i start address in [32i+31:32i].
REQ-005 SHALL have port req_write, input, 2 bits: 1 = write, 0 = read, per requester.
REQ-006 SHALL have port req_incr4, input, 2 bits: 1 = INCR4 burst, 0 = SINGLE, per requester.
REQ-007 SHALL have port req_wdata, input, 64 bits: current write beat of requester i in [32i+31:32i].
REQ-008 SHALL have port gnt, output, 2 bits: one-hot owner of the bus, or 00.
REQ-009 SHALL have port wdata_take, output, 2 bits: one-cycle pulse when the current write beat is consumed.
REQ-010 SHALL have port rdata_valid, output, 2 bits: one-cycle pulse qualifying rdata.
REQ-011 SHALL have port rdata, output, 32 bits: read beat data.
REQ-012 SHALL have port done, output, 2 bits: one-cycle pulse when the transfer ends.
REQ-013 SHALL have port err, output, 2 bits: one-cycle pulse coincident with done when the transfer ended on ERROR.
REQ-014 SHALL have AHB-Lite master ports haddr[31:0], htrans[1:0], hwrite, hsize[2:0], hburst[2:0] and hwdata[31:0] as outputs, and hrdata[31:0], hreadyout and hresp[1:0] as inputs.

Function
REQ-015 SHALL implement an FSM with states IDLE, ADDR, DATA and ERR2.
REQ-016 In IDLE with any req_valid set, SHALL grant round-robin: the requester not granted last wins on a tie; requester 0 wins first after reset.
REQ-017 On the cycle after the grant decision, SHALL assert gnt, htrans=NONSEQ (10), haddr=req_addr with bits[1:0] forced to 00, hburst=011 (INCR4) or 000 (SINGLE), and hwrite=req_write; this gives 1-cycle grant latency.
REQ-018 hsize SHALL be 010 (word) at all times.
REQ-019 An address phase SHALL be accepted only in a cycle with hreadyout=1; until then haddr, htrans, hwrite and hburst SHALL hold.
REQ-020 After an accepted beat with beats remaining, SHALL drive htrans=SEQ (11) and haddr+4 next cycle, wrapping modulo 2^32; it SHALL issue exactly 4 beats for INCR4 and 1 for SINGLE.
REQ-021 After the final address phase is accepted, SHALL drive htrans=IDLE (00) and enter DATA.
REQ-022 For a write beat accepted at cycle t, SHALL pulse wdata_take[i] at t and drive hwdata=req_wdata(t) from t+1 until that data phase completes; for reads, hwdata SHALL be 0.
REQ-023 On a read data phase completing (hreadyout=1, hresp=00), SHALL pulse rdata_valid[i] with rdata=hrdata the same cycle; rdata SHALL be registered-free pass-through or 1-cycle registered, consistently, with rdata_valid aligned to it.
REQ-024 When the last data phase completes OKAY, SHALL pulse done[i], clear gnt and return to IDLE; a minimum of one IDLE cycle SHALL separate transfers.
REQ-025 On hresp=01 with hreadyout=0 (first ERROR cycle), SHALL drive htrans=IDLE next cycle, issue no further beats and enter ERR2.
REQ-026 In ERR2, on hreadyout=1, SHALL pulse err[i] and done[i], clear gnt and return to IDLE; rdata_valid SHALL NOT pulse for an errored beat.
REQ-027 A req_valid deassertion during a granted transfer SHALL be ignored; the burst SHALL complete.
REQ-028 A new request arriving during a transfer SHALL wait; no pre-emption.
REQ-029 At most one bit of gnt, wdata_take, rdata_valid, done and err SHALL be set at any time.

Reset
REQ-030 While hrst=0, regardless of state, SHALL immediately force state=IDLE, gnt=00, all pulse outputs 0, htrans=00, haddr=0, hwrite=0, hburst=000, hwdata=0, rdata=0, and round-robin priority to requester 0; a burst in flight SHALL be abandoned.

Verification
REQ-031 Requester 0 SINGLE write, addr 0x100, wdata 0xA5A5A5A5, hreadyout=1 -> NONSEQ haddr=0x100 one cycle after req; hwdata=0xA5A5A5A5 next cycle; done[0] pulse; return to IDLE.
REQ-032 Requester 1 INCR4 read at 0x200, hreadyout low for 2 cycles on beat 2 -> haddr 0x200/0x204/0x208/0x20C with SEQ holding during wait; 4 rdata_valid[1] pulses; done[1].
REQ-033 Both request simultaneously after reset -> gnt=01 first; after done[0], gnt=10; then requester 0 re-requesting with requester 1 also requesting -> requester 0 wins.
REQ-034 ERROR on beat 2 of INCR4 write (hresp=01 with hreadyout 0 then 1) -> htrans=IDLE after first ERROR cycle; only 2 wdata_take pulses; err[i] and done[i] together.
REQ-035 hrst driven low mid-INCR4 -> outputs reset asynchronously; after release, IDLE and gnt=00 until a new req_valid.
